// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM.
// Owns pc, instret, instr_q; runs imem/dmem req/ack handshakes.
// Ports: clk, rstn (async, active-low);
//   imem_req/addr/ack/rdata: instruction fetch handshake;
//   instr_q: latched word to decoder; dec_*, imm, branch_taken: decoder/ALU;
//   dmem_req/we/ack: data handshake; rf_we: regfile strobe;
//   pc, retire, instret, halted: architectural status.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_branch,
  input  logic        dec_jal,
  input  logic        dec_rd_we,
  input  logic [4:0]  dec_rd,
  input  logic        dec_illegal,
  input  logic [31:0] imm,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [31:0] target_q;
  logic [31:0] target_d;
  logic        store_q;
  logic        take;
  logic        in_wb;
  logic        wb_ok;

  assign take     = (dec_branch & branch_taken) | dec_jal;
  assign target_d = pc + (take ? imm : 32'd4);

  assign in_wb = (state_q == S_WB);
  assign wb_ok = in_wb && (target_q[1:0] == 2'b00);

  // store_q is captured in EXEC so dmem_we depends on state regs only
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) & store_q;
  assign halted    = (state_q == S_HALT);
  assign retire    = wb_ok;
  assign rf_we     = wb_ok & dec_rd_we & (dec_rd != 5'd0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = dec_illegal ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (dec_load | dec_store) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ack) state_d = S_WB;
      S_WB:     state_d = wb_ok ? S_FETCH : S_HALT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_BOOT;
      instr_q  <= NOP;
      target_q <= RESET_PC;
      store_q  <= 1'b0;
      pc       <= RESET_PC;
      instret  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (imem_req && imem_ack) begin
        instr_q <= imem_rdata;
      end
      if (state_q == S_EXEC) begin
        target_q <= target_d;
        store_q  <= dec_store;
      end
      if (wb_ok) begin
        pc      <= target_q;
        instret <= instret + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: table-driven directed bench for core_sequencer.
// Vectors carry decoder inputs, ack waits and hand-computed results.
module tb_core_sequencer;

  logic        clk;
  logic        rstn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_q;
  logic        dec_load;
  logic        dec_store;
  logic        dec_branch;
  logic        dec_jal;
  logic        dec_rd_we;
  logic [4:0]  dec_rd;
  logic        dec_illegal;
  logic [31:0] imm;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  core_sequencer #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_q      (instr_q),
    .dec_load     (dec_load),
    .dec_store    (dec_store),
    .dec_branch   (dec_branch),
    .dec_jal      (dec_jal),
    .dec_rd_we    (dec_rd_we),
    .dec_rd       (dec_rd),
    .dec_illegal  (dec_illegal),
    .imm          (imm),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .rf_we        (rf_we),
    .pc           (pc),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    bit          ld;
    bit          st;
    bit          br;
    bit          jal;
    bit          rdwe;
    logic [4:0]  rd;
    bit          ill;
    logic [31:0] imm;
    bit          tk;
    int          iwait;
    int          dwait;
    logic [31:0] epc;
    int          ecyc;
    int          erf;
    int          edreq;
    bit          ehalt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_instret = 32'd0;
  vec_t vecs[13];
  vec_t v;

  function automatic vec_t mk(
    logic [31:0] word, bit ld, bit st, bit br, bit jal,
    bit rdwe, logic [4:0] rd, bit ill, logic [31:0] im,
    bit tk, int iw, int dw, logic [31:0] epc,
    int cyc, int rf, int dreq, bit hlt);
    vec_t r;
    r.word = word; r.ld = ld; r.st = st; r.br = br;
    r.jal = jal; r.rdwe = rdwe; r.rd = rd; r.ill = ill;
    r.imm = im; r.tk = tk; r.iwait = iw; r.dwait = dw;
    r.epc = epc; r.ecyc = cyc; r.erf = rf;
    r.edreq = dreq; r.ehalt = hlt;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_imem_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_dmem_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_dmem_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
    chk({tag, "_retire"}, {31'd0, retire}, 32'd0);
    chk({tag, "_halted"}, {31'd0, halted}, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
    chk({tag, "_instr_q"}, instr_q, 32'h0000_0013);
  endtask

  // Leaves time at posedge+1 with the FSM in FETCH.
  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    #2 chk_reset("rst");
    #1 rstn = 1'b1;
    #1 chk("boot_noreq", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1 chk("first_req", {31'd0, imem_req}, 32'd1);
    exp_instret = 32'd0;
  endtask

  // Entered at posedge+1 in FETCH; acks are high unless a wait runs.
  task automatic run_vec(input vec_t t, input int idx);
    int cyc, rf, ireq, dreq, dwe, ret, iw, dw;
    bit done;
    logic [31:0] iq0;
    string s;
    cyc = 0; rf = 0; ireq = 0; dreq = 0; dwe = 0; ret = 0;
    done = 1'b0;
    iw = t.iwait; dw = t.dwait;
    s = $sformatf("v%0d", idx);
    dec_load = t.ld; dec_store = t.st; dec_branch = t.br;
    dec_jal = t.jal; dec_rd_we = t.rdwe; dec_rd = t.rd;
    dec_illegal = t.ill; imm = t.imm; branch_taken = t.tk;
    imem_rdata = t.word;
    iq0 = instr_q;
    for (int k = 0; k < 60 && !done; k++) begin
      cyc++;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      if (imem_req) begin
        ireq++;
        if (iw > 0) begin
          imem_ack = 1'b0;
          iw--;
          chk({s, "_instr_hold"}, instr_q, iq0);
        end
      end
      if (dmem_req) begin
        dreq++;
        if (dmem_we) dwe++;
        if (dw > 0) begin
          dmem_ack = 1'b0;
          dw--;
        end
      end
      #1;
      if (rf_we) rf++;
      if (retire) ret++;
      if (retire || halted) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout actual=busy required=retire_or_halt", s);
    end
    if (ret > 0) begin
      @(posedge clk);
      #1;
    end
    if (!t.ehalt) exp_instret = exp_instret + 32'd1;
    chk({s, "_cycles"}, cyc, t.ecyc);
    chk({s, "_rf_we"}, rf, t.erf);
    chk({s, "_imem_req"}, ireq, t.iwait + 1);
    chk({s, "_dmem_req"}, dreq, t.edreq);
    chk({s, "_dmem_we"}, dwe, t.st ? t.edreq : 0);
    chk({s, "_retire"}, ret, t.ehalt ? 0 : 1);
    chk({s, "_halted"}, {31'd0, halted}, {31'd0, t.ehalt});
    chk({s, "_pc"}, pc, t.epc);
    chk({s, "_instret"}, instret, exp_instret);
    chk({s, "_instr_q"}, instr_q, t.word);
  endtask

  task automatic hold_halt(input string tag, input logic [31:0] epc);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    dec_illegal = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
      chk({tag, "_reqs"}, {30'd0, imem_req, dmem_req}, 32'd0);
      chk({tag, "_strb"}, {30'd0, rf_we, retire}, 32'd0);
    end
    chk({tag, "_pc"}, pc, epc);
    chk({tag, "_instret"}, instret, exp_instret);
  endtask

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ  = 32'hFE00_0CE3;
  localparam logic [31:0] LW   = 32'h0000_A283;
  localparam logic [31:0] SW   = 32'h0050_A023;
  localparam logic [31:0] JAL  = 32'h0000_00EF;
  localparam logic [31:0] BAD  = 32'hFFFF_FFFF;

  initial begin
    rstn = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 32'd0;
    dec_load = 1'b0; dec_store = 1'b0; dec_branch = 1'b0;
    dec_jal = 1'b0; dec_rd_we = 1'b0; dec_rd = 5'd0;
    dec_illegal = 1'b0; imm = 32'd0; branch_taken = 1'b0;

    //          word  ld st br jl we rd  il imm           tk iw dw epc  cyc rf dq h
    vecs[0]  = mk(ADDI, 0, 0, 0, 0, 1, 1, 0, 32'd1,       0, 0, 0, 4,  4, 1, 0, 0);
    vecs[1]  = mk(ADDI, 0, 0, 0, 0, 1, 2, 0, 32'd2,       0, 0, 0, 8,  4, 1, 0, 0);
    vecs[2]  = mk(ADDI, 0, 0, 0, 0, 1, 3, 0, 32'd3,       0, 0, 0, 12, 4, 1, 0, 0);
    vecs[3]  = mk(ADDI, 0, 0, 0, 0, 1, 0, 0, 32'd4,       0, 0, 0, 16, 4, 0, 0, 0);
    vecs[4]  = mk(BEQ,  0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 1, 0, 0, 8,  4, 0, 0, 0);
    vecs[5]  = mk(ADDI, 0, 0, 0, 0, 1, 1, 0, 32'd5,       0, 0, 0, 12, 4, 1, 0, 0);
    vecs[6]  = mk(ADDI, 0, 0, 0, 0, 1, 1, 0, 32'd6,       0, 0, 0, 16, 4, 1, 0, 0);
    vecs[7]  = mk(BEQ,  0, 0, 1, 0, 0, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 20, 4, 0, 0, 0);
    vecs[8]  = mk(LW,   1, 0, 0, 0, 1, 5, 0, 32'd0,       0, 0, 2, 24, 7, 1, 3, 0);
    vecs[9]  = mk(SW,   0, 1, 0, 0, 0, 0, 0, 32'd0,       0, 0, 0, 28, 5, 0, 1, 0);
    vecs[10] = mk(ADDI, 0, 0, 0, 0, 1, 6, 0, 32'd7,       0, 5, 0, 32, 9, 1, 0, 0);
    vecs[11] = mk(JAL,  0, 0, 0, 1, 1, 1, 0, 32'hFFFFFFE0, 0, 0, 0, 0,  4, 1, 0, 0);
    vecs[12] = mk(JAL,  0, 0, 0, 1, 1, 1, 0, 32'd2,       0, 0, 0, 0,  5, 0, 0, 1);

    repeat (2) @(posedge clk);
    #1 chk_reset("por");
    #4 rstn = 1'b1;
    #1 chk("por_boot_noreq", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1 chk("por_first_req", {31'd0, imem_req}, 32'd1);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);
    hold_halt("jal_halt", 32'd0);

    do_reset();
    v = mk(BAD, 0, 0, 0, 0, 0, 0, 1, 32'd0, 0, 0, 0, 0, 3, 0, 0, 1);
    run_vec(v, 20);
    hold_halt("ill_halt", 32'd0);

    do_reset();
    run_vec(vecs[0], 21);
    v = mk(JAL, 0, 0, 0, 1, 0, 0, 0, 32'hFFFFFFF8, 0, 0, 0, 32'hFFFFFFFC, 4, 0, 0, 0);
    run_vec(v, 22);
    v = mk(ADDI, 0, 0, 0, 0, 1, 1, 0, 32'd1, 0, 0, 0, 32'd0, 4, 1, 0, 0);
    run_vec(v, 23);
    v = mk(ADDI, 0, 0, 0, 0, 1, 1, 0, 32'd1, 0, 0, 0, 32'd4, 4, 1, 0, 0);
    run_vec(v, 24);

    dec_load = 1'b1; dec_store = 1'b0; dec_branch = 1'b0;
    dec_jal = 1'b0; dec_rd_we = 1'b1; dec_rd = 5'd5;
    dec_illegal = 1'b0; imem_rdata = LW;
    imem_ack = 1'b1; dmem_ack = 1'b0;
    for (int k = 0; k < 20 && !dmem_req; k++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_mem_req", {31'd0, dmem_req}, 32'd1);
    #2 rstn = 1'b0;
    #1 chk_reset("mid_mem");
    #2 rstn = 1'b1;
    #1 chk("mid_boot_noreq", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1 chk("mid_fetch_req", {31'd0, imem_req}, 32'd1);
    chk("mid_fetch_addr", imem_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the core. It fetches an instruction word and holds it in `instr_q`, which feeds the instruction decoder. It then walks the decoded instruction through decode, execute, optional memory access and writeback. It owns the PC, the retired-instruction counter and the register-file write enable, and it runs the request/acknowledge handshakes to instruction memory and data memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous assert, active-low; deassertion synchronised externally.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_ack`  in  1  fetch done; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched word.
- `instr_q`  out  32  latched instruction, fed to decoder.
- `dec_load`, `dec_store`, `dec_branch`, `dec_jal`  in  1 each  decoder class flags for `instr_q`.
- `dec_rd_we`  in  1  instruction writes `rd`.
- `dec_rd`  in  5  destination register.
- `dec_illegal`  in  1  opcode not recognised.
- `imm`  in  32  decoder immediate, sign-extended.
- `branch_taken`  in  1  branch comparison result from ALU; sampled in EXEC.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data access is a store.
- `dmem_ack`  in  1  data access done.
- `rf_we`  out  1  register-file write strobe.
- `pc`  out  32  current PC.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `instret`  out  32  retired-instruction count.
- `halted`  out  1  core stopped.

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is BOOT.
- BOOT: drives no requests; goes to FETCH on the next cycle.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`: `instr_q`<=`imem_rdata`, go to DECODE.
  - Without `imem_ack`: stay in FETCH with `imem_req` held high.
- DECODE: one cycle. If `dec_illegal`, go to HALT; otherwise go to EXEC.
- EXEC: one cycle.
  - Registers `take` = (`dec_branch` & `branch_taken`) | `dec_jal`.
  - Registers `target` = `take` ? `pc`+`imm` : `pc`+4.
  - Go to MEM if `dec_load`|`dec_store`, else to WB.
- MEM:
  - `dmem_req`=1 and `dmem_we`=`dec_store`, both held until `dmem_ack`.
  - On `dmem_ack`, go to WB.
- WB, when `target[1:0]`==0:
  - `rf_we`=`dec_rd_we` & (`dec_rd`!=0).
  - `pc`<=`target`, `retire`=1, `instret`<=`instret`+1.
  - Go to FETCH.
- WB, when `target[1:0]`!=0 (misaligned):
  - `rf_we`=0, `retire`=0; `pc` and `instret` unchanged.
  - Go to HALT.
- HALT: sticky until reset. `halted`=1; all request and strobe outputs are 0.
- Arithmetic:
  - PC additions are 32-bit modulo 2^32; 32'hFFFF_FFFC+4 gives 0.
  - `instret` wraps from 32'hFFFF_FFFF to 0.
- An `imem_ack` or `dmem_ack` arriving outside the state that requested it is ignored.
- Decoder inputs are only meaningful from DECODE through WB; the FSM does not sample them in other states.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; `instr_q`=32'h0000_0013 (nop); `instret`=0.
  - `imem_req`, `dmem_req`, `dmem_we`, `rf_we`, `retire`, `halted` all 0.
- `imem_req`, `dmem_req`, `dmem_we` and `halted` are decoded from the state register only.
- `rf_we` and `retire` are high only in WB.
- The ack may arrive in the same cycle the request first rises; that is a zero-wait access.
- Latency with zero-wait memories:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- Each wait cycle on an ack adds exactly one cycle.
- First `imem_req` is asserted in the second cycle after `rstn` deasserts (BOOT, then FETCH).
- Reset mid-operation:
  - Asynchronous clear to reset values, including requests dropped mid-transaction.
  - Memories must tolerate a request withdrawn without an ack.
- `pc` and `instret` change only on the clock edge that ends WB.

## Test plan
- **Zero-wait straight-line:** ack tied high, three addi words, `RESET_PC`=0.
  - `retire` pulses every 4 cycles.
  - `pc` steps 0 -> 4 -> 8 -> 12; `instret`=3.
- **Fetch wait states:** hold `imem_ack` low for 5 cycles at `pc`=0.
  - `imem_req` stays high for 6 cycles and `instr_q` is unchanged until the ack.
  - First retire lands 5 cycles later than in the zero-wait case.
- **Taken branch:**
  - beq with `imm`=-8 at `pc`=16 and `branch_taken`=1 -> `pc`=8, `rf_we`=0.
  - Repeat with `branch_taken`=0 -> `pc`=20.
- **Load with `dmem_ack` delayed 2 cycles, `dec_rd`=5:**
  - `dmem_req` high for 3 cycles with `dmem_we`=0.
  - `rf_we` pulses once in WB; total 7 cycles.
  - A store with `dec_rd_we`=0 never asserts `rf_we`.
- **Halts:**
  - Illegal instruction -> `halted`=1 two cycles after the fetch ack, `instret` unchanged.
  - jal with `imm`=2 -> HALT with `pc` unchanged and no retire.
  - Both hold until `rstn` drops.
- **Reset mid-MEM:** drop `rstn` while `dmem_req`=1.
  - `dmem_req` falls without a clock edge.
  - `pc`=`RESET_PC`, `instret`=0, `instr_q`=32'h0000_0013.
  - After release, BOOT then FETCH.
